// File: rtl/kernel_buffer_pkg.sv
// Shared definitions for the kernel buffer writer and distributor: state
// encoding, default geometry and bank packing helpers.
package kernel_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEPTH_DEF = 2;
   localparam int W_DEF     = 16;
   localparam int AW_DEF    = 8;

   // All-lanes-filled mask for a D-lane row.
   function automatic logic [31:0] full_mask(input int d);
      return (32'd1 << d) - 32'd1;
   endfunction

   // Bank i occupies bits [w*(i+1)-1 -: w] of a packed row.
   function automatic int lane_lsb(input int lane, input int w);
      return lane * w;
   endfunction

endpackage

// File: rtl/kernel_row_packer.sv
// Packs consecutive weights into a D-lane row and emits the row with its
// fill mask one cycle after the row completes or is flushed.
module kernel_row_packer
   import kernel_buffer_pkg::*;
#(
   parameter int depth = DEPTH_DEF,
   parameter int D     = 1 << depth,
   parameter int W     = W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic             flush_i,
   input  logic [W-1:0]     data_i,
   output logic             issue_o,
   output logic [D-1:0]     row_mask_o,
   output logic [W*D-1:0]   row_data_o
);

   localparam logic [D-1:0] FULL = D'(full_mask(D));

   logic [depth-1:0] lane_q;
   logic [D-1:0]     fill_q, fill_d;
   logic [W*D-1:0]   pack_q, pack_d;
   logic [D-1:0]     mask_q;
   logic [W*D-1:0]   data_q;

   always_comb begin
      pack_d = pack_q;
      fill_d = fill_q;
      pack_d[lane_lsb(int'(lane_q), W) +: W] = data_i;
      fill_d[lane_q] = 1'b1;
   end

   assign issue_o = push_i && ((fill_d == FULL) || flush_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         lane_q <= '0;
         fill_q <= '0;
         pack_q <= '0;
         mask_q <= '0;
         data_q <= '0;
      end else begin
         mask_q <= '0;
         if (clear_i) begin
            lane_q <= '0;
            fill_q <= '0;
            pack_q <= '0;
         end else if (issue_o) begin
            // Row leaves; pack register restarts empty so a short tail row carries zeros.
            mask_q <= fill_d;
            data_q <= pack_d;
            lane_q <= '0;
            fill_q <= '0;
            pack_q <= '0;
         end else if (push_i) begin
            lane_q <= lane_q + depth'(1);
            fill_q <= fill_d;
            pack_q <= pack_d;
         end
      end
   end

   assign row_mask_o = mask_q;
   assign row_data_o = data_q;

endmodule

// File: rtl/kernel_buffer_writer.sv
// Fills the D-bank kernel buffer from a serial weight stream, one row of D
// weights per write at an auto-incrementing address.
module kernel_buffer_writer
   import kernel_buffer_pkg::*;
#(
   parameter int depth = DEPTH_DEF,
   parameter int D     = 1 << depth,
   parameter int W     = W_DEF,
   parameter int AW    = AW_DEF,
   parameter int LW    = AW + depth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AW-1:0]    cfg_base,
   input  logic [LW-1:0]    cfg_len,
   input  logic [W-1:0]     in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [D-1:0]     wr_en,
   output logic [AW-1:0]    wr_addr,
   output logic [W*D-1:0]   wr_data,
   output logic             busy,
   output logic             done
);

   state_t          state_q;
   logic [AW-1:0]   addr_q;
   logic [AW-1:0]   wr_addr_q;
   logic [LW-1:0]   len_q;
   logic [LW-1:0]   cnt_q;
   logic            done_q;

   logic            xfer;
   logic            last_word;
   logic            accept_start;
   logic            issue;

   assign in_ready     = (state_q == ST_LOAD);
   assign busy         = (state_q != ST_IDLE);
   assign xfer         = in_valid && in_ready;
   assign last_word    = (cnt_q == (len_q - LW'(1)));
   assign accept_start = start && (state_q == ST_IDLE);

   kernel_row_packer #(
      .depth (depth),
      .D     (D),
      .W     (W)
   ) u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (accept_start),
      .push_i     (xfer),
      .flush_i    (last_word),
      .data_i     (in_data),
      .issue_o    (issue),
      .row_mask_o (wr_en),
      .row_data_o (wr_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wr_addr_q <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  addr_q <= cfg_base;
                  len_q  <= cfg_len;
                  cnt_q  <= '0;
                  if (cfg_len == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (xfer) begin
                  cnt_q <= cnt_q + LW'(1);
                  // Address register moves with the row so it lines up with wr_en.
                  if (issue) begin
                     wr_addr_q <= addr_q;
                     addr_q    <= addr_q + AW'(1);
                  end
                  if (last_word) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign wr_addr = wr_addr_q;
   assign done    = done_q;

endmodule

// File: doc/kernel_buffer_writer.md
Name: kernel_buffer_writer

Overview:
- Fills the D-bank kernel buffer from a serial weight stream; write-side counterpart of the kernel buffer distributor, which reads the same banks.
- Accepts W-bit weights over a valid/ready handshake and packs D consecutive weights into one buffer row, one weight per bank.
- Writes each row at an auto-incrementing address.
- Sits between the DRAM/host weight-fetch interface and the kernel buffer bank write ports.

Parameters:
- depth, 2, log2 of bank count.
- D, 1<<depth, number of kernel buffer banks (lanes).
- W, 16, weight word width.
- AW, 8, bank address width.
- LW, AW+depth, word-count width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- cfg_base  input  AW  first row address; latched on accepted start.
- cfg_len  input  LW  number of weights to load; latched on accepted start.
- in_data  input  W  weight word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  writer accepts a word this cycle.
- wr_en  output  D  per-bank write enable; bit i writes bank i.
- wr_addr  output  AW  row address, common to all banks.
- wr_data  output  W*D  bank i data is wr_data[W*(i+1)-1 -: W].
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the load completes.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. All outputs 0: wr_en, wr_addr, wr_data, in_ready, busy, done. Lane counter, word counter and pack register cleared. Reset mid-load abandons the load; no further writes are issued.
- Handshake: a word transfers when in_valid && in_ready. in_ready is registered-state combinational: it is 1 only in LOAD. The writer never applies backpressure inside LOAD.
- State IDLE: on start=1, latch cfg_base and cfg_len, clear counters, go to LOAD. If cfg_len==0, go to DONE instead; no write is issued.
- State LOAD:
  - Word k (0-based) goes to lane k mod D in the pack register, for row address cfg_base + k/D.
  - On the transfer that fills lane D-1, or on the transfer of word cfg_len-1, the pack row is registered onto wr_data next cycle.
  - That same cycle, wr_en carries a mask of the filled lanes and wr_addr carries the row address.
  - Unfilled lanes of a partial final row drive zero data and wr_en=0.
  - After a row is issued, the pack register clears and the row address increments.
  - The row address wraps modulo 2^AW silently.
- LOAD to DONE transition: on transfer of word cfg_len-1.
- State DONE: lasts exactly one cycle and coincides with the final row's wr_en cycle. done=1 in this cycle, then the state returns to IDLE.
- wr_en timing: wr_en is high for exactly one cycle per row. In all other cycles wr_en=0, and wr_data/wr_addr hold their last value.
- Latency: one cycle from the completing transfer to wr_en. Sustained throughput is one word per cycle, i.e. one row per D cycles.
- start while busy: ignored.
- in_valid outside LOAD: ignored; no transfer.
- Widths: row count = ceil(cfg_len/D). cfg_len up to 2^LW-1.

Decomposition:
- Shared package kernel_buffer_pkg:
  - State encoding: IDLE, LOAD, DONE.
  - Lane-mask helper constant for D.
  - Defaults for depth, W, AW, so the distributor and the writer agree on bank packing order.
- One natural sub-module: kernel_row_packer. It holds the lane counter, the pack register and the fill-mask generation, and emits a row plus mask on a complete or flush pulse. The FSM and the address/word counters stay in the top module.

Test Plan (D=4, W=16, AW=8):
- Full rows: base=0x10, len=8, words 0x0001..0x0008 with in_valid held high → wr_en=4'b1111 at addr 0x10 with data {0x0004,0x0003,0x0002,0x0001} (bank3..bank0), then addr 0x11 with {0x0008,0x0007,0x0006,0x0005}. done pulses in the same cycle as the second write. Total 9 cycles from LOAD entry.
- Partial tail: base=0, len=6 → row0 wr_en=1111; row1 at addr 1 with wr_en=4'b0011, lanes 2–3 data 0, done with that write.
- Gapped input: len=4, in_valid toggling 1,0,1,0,… → single write issued one cycle after the 4th transfer. No write and no lane advance on invalid cycles.
- Zero length and ignored start: len=0 → done one cycle after IDLE→DONE, wr_en never asserted. A start pulse during LOAD changes neither cfg nor counters.
- Wrap and reset: base=0xFF, len=8 → writes at 0xFF then 0x00. A separate run asserts rst after 2 accepted words → next cycle all outputs 0, state IDLE, no wr_en ever issued for that load.
